// File: rtl/countdown_nbits.sv
// Programmable N-bit down-counter/timer: load on start, decrement per unpaused
// cycle, one-cycle done pulse on terminal count, optional auto-reload.
module countdown_nbits #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] load_value,
  input  logic         auto_reload,
  input  logic         pause,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         zero
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         done_q, done_d;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (start) begin
      // A zero load expires immediately regardless of current state.
      if (load_value == '0) begin
        count_d = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        count_d  = load_value;
        reload_d = load_value;
        state_d  = RUN;
      end
    end else if (state_q == RUN && !pause) begin
      if (count_q == ONE) begin
        done_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign zero  = (count_q == '0);

endmodule
